reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, register-file word address width.
REQ-002 Parameter DATA_WIDTH, default 16, register data width.
REQ-003 Parameter NUM_REQ, default 3, requester count; index 0 is the GPMC host port.
REQ-004 Parameter HOST_MAX, default 4, consecutive host grants allowed while a lower requester waits.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_REQ  per-requester access request, held until its gnt.
REQ-008 req_we  input  NUM_REQ  per-requester write(1)/read(0).
REQ-009 req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
REQ-011 gnt  output  NUM_REQ  one-cycle one-hot grant pulse.
REQ-012 rvalid  output  NUM_REQ  one-cycle one-hot read-data-valid pulse.
REQ-013 rdata  output  DATA_WIDTH  read data, valid when any rvalid bit is high.
REQ-014 mem_en  output  1  register-file access strobe.
REQ-015 mem_we  output  1  register-file write enable, qualified by mem_en.
REQ-016 mem_addr  output  ADDR_WIDTH  register-file address.
REQ-017 mem_wdata  output  DATA_WIDTH  register-file write data.
REQ-018 mem_rdata  input  DATA_WIDTH  register-file read data, valid one cycle after mem_en with mem_we=0.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, ACCESS, RWAIT, RESP; one access in flight at a time.
REQ-021 IDLE: if any req bit high, select winner, latch winner index, req_we, req_addr, req_wdata, go to ACCESS; else stay.
REQ-022 Winner: requester 0 if req[0] and host streak count < HOST_MAX or no req[1..NUM_REQ-1] pending; otherwise round-robin among 1..NUM_REQ-1 starting at rr pointer.
REQ-023 Host streak counter increments on each host grant while any lower request is pending, clears on any non-host grant or when no lower request is pending, saturates at HOST_MAX.
REQ-024 rr pointer updates to (winner+1), wrapping from NUM_REQ-1 to 1, only on non-host grants.
REQ-025 ACCESS (one cycle): gnt[winner]=1, mem_en=1, mem_we/mem_addr/mem_wdata from latched command; next state IDLE if write, RWAIT if read.
REQ-026 RWAIT (one cycle): capture mem_rdata into rdata register; go to RESP.
REQ-027 RESP (one cycle): rvalid[winner]=1, rdata holds captured value; go to IDLE.
REQ-028 Latency from request sampled in IDLE: gnt after 1 cycle; read rvalid after 3 cycles; write occupies 2 cycles, read 4.
REQ-029 Command latched in IDLE is executed even if req drops before gnt; requester dropping req early gets no abort.
REQ-030 Requests arriving in non-IDLE states wait; host has no preemption of an in-flight access.
REQ-031 mem_en, gnt, rvalid are zero outside ACCESS/RESP respectively; mem_addr/mem_wdata/mem_we are don't-care when mem_en=0 but held at latched values.
REQ-032 rdata retains last captured value until the next RWAIT.
REQ-033 NUM_REQ=1 degenerates to host-only; rr logic unused, no grant outside index 0.

Reset
REQ-034 rst_n low asynchronously forces state IDLE; gnt, rvalid, mem_en, mem_we, busy to 0; mem_addr, mem_wdata, rdata to 0; rr pointer to 1; host streak to 0.
REQ-035 Reset asserted mid-access cancels it: no gnt, rvalid or mem_en pulse after rst_n rises until a new request is sampled in IDLE.

Verification
REQ-036 Host write: req[0]=1, we=1, addr=4, wdata=0xA5A5 -> next cycle gnt=001, mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xA5A5; busy low one cycle later.
REQ-037 Read: req[1]=1, we=0, addr=6, mem_rdata=0x1234 on cycle after mem_en -> gnt=010 at +1, rvalid=010 and rdata=0x1234 at +3.
REQ-038 Round-robin: req[1] and req[2] held high continuously, writes -> gnts alternate 010, 100, 010, 100.
REQ-039 Starvation guard: req[0] and req[1] held high, writes, HOST_MAX=4 -> gnt sequence 001 x4, 010, 001 x4, 010.
REQ-040 Reset mid-read: rst_n low during RWAIT -> outputs zero immediately, no rvalid after release, next request granted normally with rr pointer at 1.

Source files
------------

// File: rtl/reg_arbiter_if.sv
// Requester and register-file bus for reg_arbiter.
// The arbiter takes the slave view; the requesters and memory side take the master view.
interface reg_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 3
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          busy;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/reg_arbiter.sv
// Register-file arbiter: host port 0 has priority with a starvation guard,
// ports 1..NUM_REQ-1 share round-robin; one access in flight at a time.
module reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 3,
  parameter int HOST_MAX   = 4
) (
  input logic           clk,
  input logic           rst_n,
  reg_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOST_MAX + 1);
  localparam int NLOW  = (NUM_REQ > 1) ? NUM_REQ - 1 : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      streak_q, streak_d;

  logic                  lowerPending;
  logic                  hostWins;
  logic                  rrFound;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      rrPick;
  logic [IDX_W-1:0]      pick;

  // Winner selection; the round-robin scan only covers the non-host ports.
  always_comb begin
    lowerPending = |(bus.req & ~NUM_REQ'(1));
    hostWins     = bus.req[0] && ((streak_q < CNT_W'(HOST_MAX)) || !lowerPending);
    rrPick       = '0;
    rrFound      = 1'b0;
    cand         = '0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      cand = IDX_W'(1 + ((int'(rr_q) - 1 + k) % NLOW));
      if (!rrFound && bus.req[cand]) begin
        rrPick  = cand;
        rrFound = 1'b1;
      end
    end
    pick = hostWins ? '0 : rrPick;
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rr_d          = rr_q;
    streak_d      = lowerPending ? streak_q : '0;
    bus.gnt       = '0;
    bus.rvalid    = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rdata     = rdata_q;
    bus.busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d   = pick;
          we_d    = bus.req_we[pick];
          addr_d  = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          state_d = ACCESS;
          // The streak only counts host grants that made someone else wait.
          if (pick == '0) begin
            if (lowerPending && (streak_q != CNT_W'(HOST_MAX))) begin
              streak_d = streak_q + CNT_W'(1);
            end
          end else begin
            streak_d = '0;
            rr_d     = (int'(pick) + 1 >= NUM_REQ) ? IDX_W'(1) : pick + IDX_W'(1);
          end
        end
      end
      ACCESS: begin
        bus.gnt    = NUM_REQ'(1) << win_q;
        bus.mem_en = 1'b1;
        state_d    = we_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        bus.rvalid = NUM_REQ'(1) << win_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rr_q     <= IDX_W'(1);
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rr_q     <= rr_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: directed vector table, held-request
// sequences, reset mid-read, then random traffic against a transaction model.
module tb_reg_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NR = 3;
  localparam int HM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic memClear = 1'b1;

  always #5 clk = ~clk;

  reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .HOST_MAX(HM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Register file: read data appears the cycle after a read strobe.
  logic [DW-1:0] envMem [16];
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 16; i++) envMem[i] <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) envMem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= envMem[bus.mem_addr];
    end
  end

  int checks = 0;
  int passes = 0;

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NR-1:0] expGnt;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs [9];
  logic [NR-1:0] expSeq [$];

  // Transaction-level reference state for the random phase.
  int cyc, freeAt, startCyc, tWin, streak, rr;
  bit hasTxn, tRead;
  logic [AW-1:0] tAddr;
  logic [DW-1:0] tWdata, tRdata;
  logic [DW-1:0] refMem [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clearReqs();
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic driveReq(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]                = 1'b1;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    int lat;
    bit got;
    clearReqs();
    driveReq(v.idx, v.we, v.addr, v.wdata);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.gnt != '0) got = 1'b1;
    end
    checkOutput($sformatf("vec%0d gnt latency", n), lat, 1);
    checkOutput($sformatf("vec%0d gnt", n), bus.gnt, v.expGnt);
    checkOutput($sformatf("vec%0d mem_en", n), bus.mem_en, 1);
    checkOutput($sformatf("vec%0d mem_we", n), bus.mem_we, v.we);
    checkOutput($sformatf("vec%0d mem_addr", n), bus.mem_addr, v.addr);
    if (v.we) checkOutput($sformatf("vec%0d mem_wdata", n), bus.mem_wdata, v.wdata);
    clearReqs();
    if (!v.we) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d rwait rvalid", n), bus.rvalid, 0);
      checkOutput($sformatf("vec%0d rwait busy", n), bus.busy, 1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d rvalid", n), bus.rvalid, v.expGnt);
      checkOutput($sformatf("vec%0d rdata", n), bus.rdata, v.expRdata);
    end
    @(negedge clk);
    checkOutput($sformatf("vec%0d busy after", n), bus.busy, 0);
    checkOutput($sformatf("vec%0d gnt after", n), bus.gnt, 0);
  endtask

  // Holds the requesters in mask (writes) and compares successive grants to expSeq.
  task automatic runHeld(input string name, input logic [NR-1:0] mask);
    int n;
    int cycles;
    clearReqs();
    for (int i = 0; i < NR; i++)
      if (mask[i]) driveReq(i, 1'b1, AW'(i + 8), DW'(16'h1000 + i));
    n = 0;
    cycles = 0;
    while (n < expSeq.size() && cycles < 80) begin
      @(negedge clk);
      cycles++;
      if (bus.gnt != '0) begin
        checkOutput($sformatf("%s gnt#%0d", name, n), bus.gnt, expSeq[n]);
        n++;
      end
    end
    if (n < expSeq.size()) checkOutput($sformatf("%s grant count", name), n, expSeq.size());
    clearReqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic modelStep();
    bit lowerPend;
    int win;
    cyc++;
    lowerPend = (bus.req >> 1) != '0;
    if (!lowerPend) streak = 0;
    if (cyc >= freeAt && bus.req != '0) begin
      win = -1;
      if (bus.req[0] && (streak < HM || !lowerPend)) win = 0;
      else
        for (int k = 0; k < NR - 1; k++) begin
          int c;
          c = 1 + ((rr - 1 + k) % (NR - 1));
          if (win < 0 && bus.req[c]) win = c;
        end
      if (win == 0) streak = lowerPend ? ((streak < HM) ? streak + 1 : HM) : 0;
      else begin
        streak = 0;
        rr = (win + 1 > NR - 1) ? 1 : win + 1;
      end
      hasTxn   = 1'b1;
      startCyc = cyc;
      tWin     = win;
      tRead    = !bus.req_we[win];
      tAddr    = bus.req_addr[win*AW +: AW];
      tWdata   = bus.req_wdata[win*DW +: DW];
      if (tRead) tRdata = refMem[tAddr];
      else refMem[tAddr] = tWdata;
      freeAt = cyc + (tRead ? 4 : 2);
    end
  endtask

  task automatic checkRandom();
    logic [NR-1:0] eGnt, eRv;
    eGnt = (hasTxn && cyc == startCyc) ? NR'(1) << tWin : '0;
    eRv  = (hasTxn && tRead && cyc == startCyc + 2) ? NR'(1) << tWin : '0;
    checkOutput($sformatf("rand gnt @%0d", cyc), bus.gnt, eGnt);
    checkOutput($sformatf("rand rvalid @%0d", cyc), bus.rvalid, eRv);
    checkOutput($sformatf("rand mem_en @%0d", cyc), bus.mem_en, eGnt != '0);
    checkOutput($sformatf("rand busy @%0d", cyc), bus.busy, hasTxn && (cyc < freeAt - 1));
    if (eGnt != '0) begin
      checkOutput($sformatf("rand mem_we @%0d", cyc), bus.mem_we, !tRead);
      checkOutput($sformatf("rand mem_addr @%0d", cyc), bus.mem_addr, tAddr);
      if (!tRead) checkOutput($sformatf("rand mem_wdata @%0d", cyc), bus.mem_wdata, tWdata);
    end
    if (eRv != '0) checkOutput($sformatf("rand rdata @%0d", cyc), bus.rdata, tRdata);
  endtask

  initial begin
    int lat;
    bit got;
    vecs[0] = '{0, 1'b1, 4'h4, 16'hA5A5, 3'b001, 16'h0000};
    vecs[1] = '{1, 1'b1, 4'h6, 16'h1234, 3'b010, 16'h0000};
    vecs[2] = '{1, 1'b0, 4'h6, 16'h5555, 3'b010, 16'h1234};
    vecs[3] = '{2, 1'b1, 4'hF, 16'hBEEF, 3'b100, 16'h0000};
    vecs[4] = '{0, 1'b0, 4'h4, 16'h0000, 3'b001, 16'hA5A5};
    vecs[5] = '{2, 1'b0, 4'hF, 16'h0000, 3'b100, 16'hBEEF};
    vecs[6] = '{2, 1'b0, 4'h3, 16'h0000, 3'b100, 16'h0000};
    vecs[7] = '{1, 1'b1, 4'h0, 16'hFFFF, 3'b010, 16'h0000};
    vecs[8] = '{0, 1'b0, 4'h0, 16'h0000, 3'b001, 16'hFFFF};

    clearReqs();
    repeat (3) @(negedge clk);
    checkOutput("reset gnt", bus.gnt, 0);
    checkOutput("reset rvalid", bus.rvalid, 0);
    checkOutput("reset mem_en", bus.mem_en, 0);
    checkOutput("reset mem_we", bus.mem_we, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 0);
    checkOutput("reset rdata", bus.rdata, 0);
    rst_n = 1'b1;
    memClear = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 9; n++) applyStimulus(vecs[n], n);

    // rdata must survive an intervening write untouched.
    applyStimulus(vecs[3], 9);
    checkOutput("rdata retained", bus.rdata, 16'hFFFF);

    resetDut();
    expSeq = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
    runHeld("rr", 3'b110);

    resetDut();
    expSeq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
               3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    runHeld("starve", 3'b011);

    // Reset during RWAIT cancels the read and restores the rr pointer.
    clearReqs();
    driveReq(1, 1'b0, 4'h6, 16'h0000);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.gnt != '0) got = 1'b1;
    end
    checkOutput("midrd gnt", bus.gnt, 3'b010);
    clearReqs();
    @(negedge clk);
    checkOutput("midrd busy before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrd busy", bus.busy, 0);
    checkOutput("midrd mem_en", bus.mem_en, 0);
    checkOutput("midrd rvalid", bus.rvalid, 0);
    checkOutput("midrd mem_addr", bus.mem_addr, 0);
    checkOutput("midrd rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrd quiet %0d", i), {bus.gnt, bus.rvalid, bus.mem_en}, 0);
    end
    driveReq(1, 1'b1, 4'h2, 16'h0101);
    driveReq(2, 1'b1, 4'h3, 16'h0202);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.gnt != '0) got = 1'b1;
    end
    checkOutput("midrd regrant", bus.gnt, 3'b010);
    clearReqs();
    repeat (3) @(negedge clk);

    // Random traffic against the transaction model.
    @(negedge clk);
    rst_n = 1'b0;
    memClear = 1'b1;
    repeat (2) @(negedge clk);
    memClear = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) refMem[i] = '0;
    cyc = 0; freeAt = 0; startCyc = 0; tWin = 0; streak = 0; rr = 1;
    hasTxn = 1'b0; tRead = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkRandom();
      for (int i = 0; i < NR; i++)
        if (bus.req[i] && bus.gnt[i]) bus.req[i] = 1'b0;
      for (int i = 0; i < NR; i++)
        if (!bus.req[i] && $urandom_range(0, 99) < ((i == 0) ? 45 : 25))
          driveReq(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
